// File: rtl/hyperram_burst_split.sv
// hyperram_burst_split
//   Splits Avalon-MM client bursts (1..255 words, burstcount 0 taken as 1)
//   into sub-bursts of at most G_MAX_BURST words. A sub-burst never crosses a
//   G_MAX_BURST-aligned word boundary, so each one fits a single HyperRAM
//   wrapped-burst window. Register-space accesses (address bit 31 set) are
//   never split. Read data is forwarded combinationally and in order.
// Ports
//   clk_i, rst_i             : clock, asynchronous active-high reset
//   s_avm_*                  : client slave port (command, write data, read data)
//   m_avm_*                  : master port towards the HyperRAM configurator
module hyperram_burst_split #(
  parameter int unsigned G_MAX_BURST = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_avm_write_i,
  input  logic        s_avm_read_i,
  input  logic [31:0] s_avm_address_i,
  input  logic [15:0] s_avm_writedata_i,
  input  logic [1:0]  s_avm_byteenable_i,
  input  logic [7:0]  s_avm_burstcount_i,
  output logic [15:0] s_avm_readdata_o,
  output logic        s_avm_readdatavalid_o,
  output logic        s_avm_waitrequest_o,
  output logic        m_avm_write_o,
  output logic        m_avm_read_o,
  output logic [31:0] m_avm_address_o,
  output logic [15:0] m_avm_writedata_o,
  output logic [1:0]  m_avm_byteenable_o,
  output logic [7:0]  m_avm_burstcount_o,
  input  logic [15:0] m_avm_readdata_i,
  input  logic        m_avm_readdatavalid_i,
  input  logic        m_avm_waitrequest_i
);

  typedef enum logic [1:0] {IDLE, WR, RD_ACK, RD_ISSUE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cur_addr;
  logic [7:0]  r_remaining;
  logic [7:0]  r_sub_len;
  logic [7:0]  r_sub_left;

  logic [7:0]  w_bc;
  logic        w_beat;
  logic [31:0] w_addr_p1;
  logic [31:0] w_addr_sub;
  logic [7:0]  w_len_cmd;
  logic [7:0]  w_len_cur;
  logic [7:0]  w_len_wr_next;
  logic [7:0]  w_len_rd_next;

  // Words left before the next window boundary, capped by the words remaining.
  // Only the low address byte matters because G_MAX_BURST <= 128.
  function automatic logic [7:0] f_sub_len(input logic top, input logic [7:0] low,
                                           input logic [7:0] rem);
    logic [7:0] room;
    room = 8'(G_MAX_BURST) - (low & 8'(G_MAX_BURST - 1));
    if (top || (rem < room)) return rem;
    return room;
  endfunction

  // Bit 31 selects the address space and is never carried into.
  function automatic logic [31:0] f_inc(input logic [31:0] addr, input logic [7:0] n);
    return {addr[31], addr[30:0] + {23'd0, n}};
  endfunction

  assign w_bc          = (s_avm_burstcount_i == 8'd0) ? 8'd1 : s_avm_burstcount_i;
  assign w_beat        = s_avm_write_i & ~m_avm_waitrequest_i;
  assign w_addr_p1     = f_inc(r_cur_addr, 8'd1);
  assign w_addr_sub    = f_inc(r_cur_addr, r_sub_len);
  assign w_len_cmd     = f_sub_len(s_avm_address_i[31], s_avm_address_i[7:0], w_bc);
  assign w_len_cur     = f_sub_len(r_cur_addr[31], r_cur_addr[7:0], r_remaining);
  assign w_len_wr_next = f_sub_len(w_addr_p1[31], w_addr_p1[7:0], r_remaining - 8'd1);
  assign w_len_rd_next = f_sub_len(w_addr_sub[31], w_addr_sub[7:0], r_remaining - r_sub_len);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (s_avm_write_i)     w_next = WR;
        else if (s_avm_read_i) w_next = RD_ACK;
      end
      WR:       if (w_beat && (r_remaining == 8'd1)) w_next = IDLE;
      RD_ACK:   w_next = RD_ISSUE;
      RD_ISSUE: if (!m_avm_waitrequest_i && (r_remaining == r_sub_len)) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    s_avm_waitrequest_o = 1'b1;
    m_avm_write_o       = 1'b0;
    m_avm_read_o        = 1'b0;
    case (r_state)
      WR: begin
        m_avm_write_o       = s_avm_write_i;
        s_avm_waitrequest_o = m_avm_waitrequest_i;
      end
      RD_ACK:   s_avm_waitrequest_o = 1'b0;
      RD_ISSUE: m_avm_read_o = 1'b1;
      default: ;
    endcase
  end

  assign m_avm_address_o       = r_cur_addr;
  assign m_avm_burstcount_o    = r_sub_len;
  assign m_avm_writedata_o     = s_avm_writedata_i;
  assign m_avm_byteenable_o    = s_avm_byteenable_i;
  assign s_avm_readdata_o      = m_avm_readdata_i;
  assign s_avm_readdatavalid_o = m_avm_readdatavalid_i;

  // Datapath counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_sub_len   <= '0;
      r_sub_left  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_avm_write_i) begin
            r_cur_addr  <= s_avm_address_i;
            r_remaining <= w_bc;
            r_sub_len   <= w_len_cmd;
            r_sub_left  <= w_len_cmd;
          end else if (s_avm_read_i) begin
            r_cur_addr  <= s_avm_address_i;
            r_remaining <= w_bc;
          end
        end
        WR: begin
          if (w_beat) begin
            r_cur_addr  <= w_addr_p1;
            r_remaining <= r_remaining - 8'd1;
            // Reload on the last beat of a sub-burst so the next one starts
            // without a bubble.
            if ((r_sub_left == 8'd1) && (r_remaining != 8'd1)) begin
              r_sub_len  <= w_len_wr_next;
              r_sub_left <= w_len_wr_next;
            end else begin
              r_sub_left <= r_sub_left - 8'd1;
            end
          end
        end
        RD_ACK: r_sub_len <= w_len_cur;
        RD_ISSUE: begin
          if (!m_avm_waitrequest_i) begin
            r_cur_addr  <= w_addr_sub;
            r_remaining <= r_remaining - r_sub_len;
            if (r_remaining != r_sub_len) r_sub_len <= w_len_rd_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperram_burst_split.sv
module tb_hyperram_burst_split;
  localparam int unsigned G = 16;
  localparam int BUDGET = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_write, s_read;
  logic [31:0] s_addr;
  logic [15:0] s_wdata;
  logic [1:0]  s_be;
  logic [7:0]  s_bc;
  logic [15:0] s_rdata;
  logic        s_rvalid, s_wait;
  logic        m_write, m_read;
  logic [31:0] m_addr;
  logic [15:0] m_wdata;
  logic [1:0]  m_be;
  logic [7:0]  m_bc;
  logic [15:0] m_rdata;
  logic        m_rvalid, m_wait;

  int total = 0;
  int bad   = 0;

  typedef struct {logic [31:0] a; int unsigned n;} sub_t;
  sub_t exp_q[$];

  hyperram_burst_split #(.G_MAX_BURST(G)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_avm_write_i(s_write), .s_avm_read_i(s_read), .s_avm_address_i(s_addr),
    .s_avm_writedata_i(s_wdata), .s_avm_byteenable_i(s_be), .s_avm_burstcount_i(s_bc),
    .s_avm_readdata_o(s_rdata), .s_avm_readdatavalid_o(s_rvalid), .s_avm_waitrequest_o(s_wait),
    .m_avm_write_o(m_write), .m_avm_read_o(m_read), .m_avm_address_o(m_addr),
    .m_avm_writedata_o(m_wdata), .m_avm_byteenable_o(m_be), .m_avm_burstcount_o(m_bc),
    .m_avm_readdata_i(m_rdata), .m_avm_readdatavalid_i(m_rvalid), .m_avm_waitrequest_i(m_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference split: walk the burst window by window.
  task automatic build(input logic [31:0] addr, input int unsigned bc);
    longint unsigned low;
    int unsigned r, room, len;
    logic top;
    exp_q.delete();
    r    = (bc == 0) ? 1 : bc;
    top  = addr[31];
    low  = longint'(addr[30:0]);
    while (r > 0) begin
      room = top ? r : int'(longint'(G) - (low % longint'(G)));
      len  = (r < room) ? r : room;
      exp_q.push_back('{{top, 31'(low)}, len});
      low  = (low + longint'(len)) % (64'd1 << 31);
      r    = r - len;
    end
  endtask

  function automatic logic [31:0] addr_off(input logic [31:0] a, input int unsigned off);
    return {a[31], a[30:0] + 31'(off)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_idle_wait"}, 32'(s_wait), 32'd1);
    chk({tag, "_idle_mwr"}, 32'(m_write), 32'd0);
    chk({tag, "_idle_mrd"}, 32'(m_read), 32'd0);
    tick();
  endtask

  // mode 0: no stalls/gaps, 1: m_wait high for cycles 3..7, 2: random stalls and gaps
  task automatic do_write(input logic [31:0] addr, input logic [7:0] bc, input int mode,
                          input bit fixed, input logic [15:0] fixed_val);
    logic [15:0] d[$];
    logic [1:0]  be[$];
    int n, cb, sub, off, cyc;
    n = (bc == 0) ? 1 : int'(bc);
    build(addr, bc);
    for (int i = 0; i < n; i++) begin
      d.push_back(fixed ? fixed_val : 16'($urandom));
      be.push_back(fixed ? 2'b11 : 2'($urandom));
    end
    cb = 0; sub = 0; off = 0; cyc = 0;
    s_write = 1'b1; s_addr = addr; s_bc = bc; s_wdata = d[0]; s_be = be[0]; m_wait = 1'b0;
    @(negedge clk);
    chk("wr_cmd_wait", 32'(s_wait), 32'd1);
    chk("wr_cmd_mwr", 32'(m_write), 32'd0);
    tick();
    cyc = 1;
    while (cb < n && cyc < BUDGET) begin
      s_wdata = d[cb];
      s_be    = be[cb];
      m_wait  = (mode == 1) ? (cyc >= 3 && cyc <= 7) :
                (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      s_write = (mode == 2) ? ($urandom_range(0, 4) != 0) : 1'b1;
      @(negedge clk);
      if (s_write) begin
        chk("wr_mwr", 32'(m_write), 32'd1);
        chk("wr_wait_mirror", 32'(s_wait), 32'(m_wait));
        chk("wr_data", 32'(m_wdata), 32'(d[cb]));
        chk("wr_be", 32'(m_be), 32'(be[cb]));
        if (sub < exp_q.size()) begin
          chk("wr_addr", m_addr, addr_off(exp_q[sub].a, off));
          chk("wr_bc", 32'(m_bc), exp_q[sub].n);
        end
        if (!m_wait) begin
          cb++;
          off++;
          if (sub < exp_q.size() && off == int'(exp_q[sub].n)) begin
            sub++;
            off = 0;
          end
        end
      end else begin
        chk("wr_gap_mwr", 32'(m_write), 32'd0);
      end
      tick();
      cyc++;
    end
    chk("wr_beats", 32'(cb), 32'(n));
    if (mode == 0) chk("wr_no_bubble", 32'(cyc), 32'(n + 1));
    s_write = 1'b0;
    m_wait  = 1'b0;
    idle_check("wr");
  endtask

  // abort_sub >= 0: pulse reset while that sub-command is presented
  task automatic do_read(input logic [31:0] addr, input logic [7:0] bc, input int mode,
                         input int abort_sub);
    int n, k, pend, got, cyc;
    logic [15:0] rd;
    n = (bc == 0) ? 1 : int'(bc);
    build(addr, bc);
    k = 0; pend = 0; got = 0; cyc = 0;
    s_read = 1'b1; s_addr = addr; s_bc = bc; m_wait = 1'b0; m_rvalid = 1'b0;
    @(negedge clk);
    chk("rd_cmd_wait", 32'(s_wait), 32'd1);
    chk("rd_cmd_mrd", 32'(m_read), 32'd0);
    tick();
    @(negedge clk);
    chk("rd_ack_wait", 32'(s_wait), 32'd0);
    chk("rd_ack_mrd", 32'(m_read), 32'd0);
    tick();
    s_read = 1'b0;
    while ((k < exp_q.size() || got < n) && cyc < BUDGET) begin
      m_wait = (mode != 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
      rd = 16'($urandom);
      m_rvalid = (pend > 0) && ($urandom_range(0, 3) != 0);
      m_rdata  = rd;
      @(negedge clk);
      if (abort_sub >= 0 && k == abort_sub) begin
        chk("rd_abort_mrd", 32'(m_read), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_swait", 32'(s_wait), 32'd1);
        chk("rst_mrd", 32'(m_read), 32'd0);
        chk("rst_mwr", 32'(m_write), 32'd0);
        chk("rst_addr", m_addr, 32'd0);
        chk("rst_bc", 32'(m_bc), 32'd0);
        m_rvalid = 1'b0;
        m_wait   = 1'b0;
        tick();
        rst = 1'b0;
        return;
      end
      if (k < exp_q.size()) begin
        chk("rd_mrd", 32'(m_read), 32'd1);
        chk("rd_swait", 32'(s_wait), 32'd1);
        chk("rd_addr", m_addr, exp_q[k].a);
        chk("rd_bc", 32'(m_bc), exp_q[k].n);
        if (!m_wait) begin
          pend += int'(exp_q[k].n);
          k++;
        end
      end else begin
        chk("rd_done_mrd", 32'(m_read), 32'd0);
        chk("rd_done_swait", 32'(s_wait), 32'd1);
      end
      chk("rd_valid", 32'(s_rvalid), 32'(m_rvalid));
      if (m_rvalid) begin
        chk("rd_data", 32'(s_rdata), 32'(rd));
        got++;
        pend--;
      end
      tick();
      cyc++;
    end
    m_rvalid = 1'b0;
    chk("rd_subcmds", 32'(k), 32'(exp_q.size()));
    chk("rd_words", 32'(got), 32'(n));
    m_wait = 1'b0;
    idle_check("rd");
  endtask

  initial begin
    logic [31:0] ra;
    rst = 1'b1;
    s_write = 1'b0; s_read = 1'b0; s_addr = '0; s_wdata = '0; s_be = '0; s_bc = '0;
    m_rdata = '0; m_rvalid = 1'b0; m_wait = 1'b0;
    @(negedge clk);
    chk("reset_swait", 32'(s_wait), 32'd1);
    chk("reset_mwr", 32'(m_write), 32'd0);
    chk("reset_mrd", 32'(m_read), 32'd0);
    chk("reset_addr", m_addr, 32'd0);
    chk("reset_bc", 32'(m_bc), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    do_write(32'h0000_0010, 8'd4, 0, 1'b0, 16'h0);
    do_write(32'h0000_000C, 8'd20, 0, 1'b0, 16'h0);
    do_read(32'h0000_0005, 8'd40, 0, -1);
    do_write(32'h8000_0800, 8'd1, 0, 1'b1, 16'hFFE6);
    do_write(32'h0000_0000, 8'd8, 1, 1'b0, 16'h0);
    do_read(32'h0000_0005, 8'd40, 0, 1);
    do_write(32'h0000_0000, 8'd1, 0, 1'b0, 16'h0);
    do_write(32'h0000_001F, 8'd0, 0, 1'b0, 16'h0);
    do_write(32'h7FFF_FFFC, 8'd8, 0, 1'b0, 16'h0);
    do_write(32'h8000_000E, 8'd20, 2, 1'b0, 16'h0);
    do_read(32'h8000_0003, 8'd30, 1, -1);
    do_read(32'h0000_0100, 8'd255, 1, -1);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 5) == 0) ra[31] = 1'b1;
      if ($urandom_range(0, 1) == 0) do_write(ra, 8'($urandom), 2, 1'b0, 16'h0);
      else                           do_read(ra, 8'($urandom), 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
